seq_detect_ctrl: RTL and testbench
==================================

// Module: seq_detect_ctrl
// PURPOSE
//  Run-time programmable serial sequence-detector controller. Holds a loadable bit pattern,
//  sequences a frame of frame_len serial bits through a match core, pulses y on each
//  match, counts matches and signals completion. Sits between a host/config master and a
//  serial bit source; replaces fixed-pattern hard-coded detector FSMs.
// PARAMETERS
//  PAT_W  8  max pattern length in bits (>=2)
//  LEN_W  4  width of cfg_len; must hold PAT_W
//  CNT_W  8  width of frame_len and match_count
// PORTS
//  clk          in   1      single clock, rising edge
//  rst          in   1      reset, asynchronous, active-low
//  cfg_we       in   1      load cfg_* (honoured in IDLE only)
//  cfg_pattern  in   PAT_W  pattern; bit[len-1] = oldest bit, bit[0] = newest bit
//  cfg_len      in   LEN_W  pattern length; 0 -> 1, >PAT_W -> PAT_W (clamped at load)
//  cfg_overlap  in   1      1 = overlapping matches, 0 = restart after each match
//  start        in   1      begin frame (honoured in IDLE only)
//  frame_len    in   CNT_W  bits in frame, sampled with start
//  x            in   1      serial data bit
//  x_valid      in   1      x is valid this cycle
//  x_ready      out  1      controller accepts x (high only in RUN)
//  y            out  1      one-cycle match pulse
//  busy         out  1      high in RUN
//  done         out  1      one-cycle frame-complete pulse
//  match_count  out  CNT_W  matches in current/last frame
//  state        out  2      FSM state, for debug
// BEHAVIOUR
//  Reset (rst=0, async): state=IDLE, y=0, done=0, busy=0, x_ready=0, match_count=0,
//   pattern=0, len=1, overlap=1, history=0, fill=0, bit count=0. Reset mid-RUN aborts
//   the frame with no done pulse.
//  States: IDLE=0, RUN=1, DONE=2 (3 unused -> IDLE).
//  IDLE: cfg_we loads pattern/len(clamped)/overlap on the edge. start with frame_len!=0
//   -> RUN; clears history, fill, bit count and match_count; latches frame_len.
//   start with frame_len==0 -> DONE, match_count cleared. cfg_we and start together:
//   config loads and the frame uses the NEW config.
//  RUN: x_ready=1. Accept = x_valid & x_ready. Per accept: history <= {history, x};
//   fill <= min(fill+1, len); bit count +1. Match when updated fill==len and
//   updated history[len-1:0]==pattern[len-1:0]. On match: y=1 on the next cycle
//   (registered, exactly 1 cycle); match_count+1 on the same edge as y rises; if
//   overlap=0, fill <= 0 (history retained, not used). Cycles without accept: no
//   change. start and cfg_we ignored.
//  Last accepted bit (bit count reaches frame_len) moves RUN -> DONE on the same edge;
//   a match on that bit still pulses y and counts, coinciding with done.
//  DONE: done=1, busy=0, x_ready=0 for exactly one cycle, then IDLE. match_count holds
//   until the next honoured start.
//  match_count cannot overflow (matches <= frame_len <= 2^CNT_W-1).
// STRUCTURE
//  seq_ctrl_pkg: state encodings, default parameter values, len clamp constants.
//  Sub-module seq_match_core: history shift register, fill counter, masked compare,
//   overlap restart; inputs shift_en/clear/len/pattern/overlap, output match.
//  Top: FSM, config registers, bit counter, match counter, output registers.
// TESTING
//  1. rst=0 at t=0 with x/start toggling -> all outputs 0, state=0; release -> IDLE.
//  2. pattern=4'b1011, len=4, overlap=1, frame_len=7, bits 1,0,1,1,0,1,1 one per cycle
//     -> y after bits 4 and 7, match_count=2, done with the 2nd y.
//  3. Same as 2 with overlap=0 -> single y after bit 4, match_count=1.
//  4. Case 2 with x_valid low every other cycle -> same y pattern per accepted bit,
//     count=2, done after 7th accept; no extra bits consumed.
//  5. start with frame_len=0 -> state 0->2->0, done 1 cycle, count=0, x_ready never 1.
//  6. cfg_len=0, pattern bit0=1 -> len=1, 5 ones -> count=5; mid-RUN cfg_we ignored;
//     rst low mid-frame -> IDLE immediately, no done.

Source files
------------

// File: rtl/seq_ctrl_pkg.sv
// Shared definitions for the programmable sequence-detector controller:
// FSM state encodings, default widths and pattern-length clamp limits.
package seq_ctrl_pkg;

   localparam int PAT_W_DEF = 8;
   localparam int LEN_W_DEF = 4;
   localparam int CNT_W_DEF = 8;

   // Shortest legal pattern; a programmed length of zero is raised to this.
   localparam int LEN_MIN   = 1;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_RUN  = 2'd1,
      ST_DONE = 2'd2
   } state_t;

endpackage

// File: rtl/seq_match_core.sv
// Serial match engine: shifts accepted bits into a history register, tracks
// how many valid bits are held (saturating at the pattern length) and flags
// a match when the newest len bits equal the low len bits of the pattern.
module seq_match_core #(
   parameter int PAT_W = 8,
   parameter int LEN_W = 4
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             shift_en,
   input  logic             clear,
   input  logic             x,
   input  logic [LEN_W-1:0] len,
   input  logic [PAT_W-1:0] pattern,
   input  logic             overlap,
   output logic             match
);

   logic [PAT_W-1:0] history;
   logic [LEN_W-1:0] fill;
   logic [PAT_W-1:0] hist_next;
   logic [LEN_W-1:0] fill_next;
   logic [PAT_W-1:0] mask;

   // Mask selecting the low len bits of history and pattern.
   function automatic logic [PAT_W-1:0] len_mask(input logic [LEN_W-1:0] l);
      logic [PAT_W-1:0] m;
      m = '0;
      for (int i = 0; i < PAT_W; i++) begin
         m[i] = (LEN_W'(i) < l);
      end
      return m;
   endfunction

   // Next history/fill and the match decision, all based on the updated values.
   always_comb begin
      hist_next = {history[PAT_W-2:0], x};
      fill_next = (fill < len) ? fill + 1'b1 : len;
      mask      = len_mask(len);
      match     = shift_en && (fill_next == len) &&
                  ((hist_next & mask) == (pattern & mask));
   end

   // History/fill update; a non-overlapping match restarts the fill count.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         history <= '0;
         fill    <= '0;
      end else if (clear) begin
         history <= '0;
         fill    <= '0;
      end else if (shift_en) begin
         history <= hist_next;
         fill    <= (match && !overlap) ? '0 : fill_next;
      end
   end

endmodule

// File: rtl/seq_detect_ctrl.sv
// Run-time programmable serial sequence-detector controller. Holds the loaded
// pattern configuration, sequences one frame of frame_len accepted bits through
// the match core, pulses y per match, counts matches and pulses done at the end.
module seq_detect_ctrl
   import seq_ctrl_pkg::*;
#(
   parameter int PAT_W = PAT_W_DEF,
   parameter int LEN_W = LEN_W_DEF,
   parameter int CNT_W = CNT_W_DEF
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             cfg_we,
   input  logic [PAT_W-1:0] cfg_pattern,
   input  logic [LEN_W-1:0] cfg_len,
   input  logic             cfg_overlap,
   input  logic             start,
   input  logic [CNT_W-1:0] frame_len,
   input  logic             x,
   input  logic             x_valid,
   output logic             x_ready,
   output logic             y,
   output logic             busy,
   output logic             done,
   output logic [CNT_W-1:0] match_count,
   output logic [1:0]       state
);

   localparam logic [LEN_W-1:0] LEN_MAX = LEN_W'(PAT_W);

   state_t           state_q;
   logic [PAT_W-1:0] pattern_q;
   logic [LEN_W-1:0] len_q;
   logic             overlap_q;
   logic [CNT_W-1:0] frame_q;
   logic [CNT_W-1:0] bit_cnt;
   logic [CNT_W-1:0] bit_nxt;
   logic             accept;
   logic             clear;
   logic             match;

   // Lengths outside 1..PAT_W are pulled to the nearest legal value at load.
   function automatic logic [LEN_W-1:0] clamp_len(input logic [LEN_W-1:0] l);
      if (l == '0)
         return LEN_W'(LEN_MIN);
      else if (l > LEN_MAX)
         return LEN_MAX;
      else
         return l;
   endfunction

   // Handshake and frame-start strobes feeding the match core.
   always_comb begin
      accept  = x_valid && x_ready;
      clear   = (state_q == ST_IDLE) && start && (frame_len != '0);
      bit_nxt = bit_cnt + 1'b1;
   end

   seq_match_core #(
      .PAT_W (PAT_W),
      .LEN_W (LEN_W)
   ) u_core (
      .clk      (clk),
      .rst      (rst),
      .shift_en (accept),
      .clear    (clear),
      .x        (x),
      .len      (len_q),
      .pattern  (pattern_q),
      .overlap  (overlap_q),
      .match    (match)
   );

   // Controller FSM with config, counters and registered outputs.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q     <= ST_IDLE;
         pattern_q   <= '0;
         len_q       <= LEN_W'(LEN_MIN);
         overlap_q   <= 1'b1;
         frame_q     <= '0;
         bit_cnt     <= '0;
         match_count <= '0;
         y           <= 1'b0;
         done        <= 1'b0;
         busy        <= 1'b0;
         x_ready     <= 1'b0;
      end else begin
         y    <= 1'b0;
         done <= 1'b0;
         case (state_q)
            ST_IDLE: begin
               if (cfg_we) begin
                  pattern_q <= cfg_pattern;
                  len_q     <= clamp_len(cfg_len);
                  overlap_q <= cfg_overlap;
               end
               if (start) begin
                  match_count <= '0;
                  if (frame_len != '0) begin
                     state_q <= ST_RUN;
                     frame_q <= frame_len;
                     bit_cnt <= '0;
                     busy    <= 1'b1;
                     x_ready <= 1'b1;
                  end else begin
                     state_q <= ST_DONE;
                     done    <= 1'b1;
                  end
               end
            end
            ST_RUN: begin
               if (accept) begin
                  bit_cnt <= bit_nxt;
                  if (match) begin
                     y           <= 1'b1;
                     match_count <= match_count + 1'b1;
                  end
                  if (bit_nxt == frame_q) begin
                     state_q <= ST_DONE;
                     done    <= 1'b1;
                     busy    <= 1'b0;
                     x_ready <= 1'b0;
                  end
               end
            end
            ST_DONE: begin
               state_q <= ST_IDLE;
            end
            default: begin
               state_q <= ST_IDLE;
               busy    <= 1'b0;
               x_ready <= 1'b0;
            end
         endcase
      end
   end

   assign state = state_q;

endmodule

// File: tb/tb_seq_detect_ctrl.sv
// Self-checking bench for seq_detect_ctrl: directed frames plus randomized
// frames compared against a bit-list reference model of the detector rules.
module tb_seq_detect_ctrl;

   logic       clk = 1'b0;
   logic       rst;
   logic       cfg_we;
   logic [7:0] cfg_pattern;
   logic [3:0] cfg_len;
   logic       cfg_overlap;
   logic       start;
   logic [7:0] frame_len;
   logic       x;
   logic       x_valid;
   logic       x_ready;
   logic       y;
   logic       busy;
   logic       done;
   logic [7:0] match_count;
   logic [1:0] state;

   int errors = 0;
   int checks = 0;

   // Reference model: configuration, accepted bits and bits since last restart.
   logic [7:0] m_pat;
   int         m_len;
   bit         m_ovl;
   int         m_cnt;
   int         since;
   bit         q[$];
   int         stim[$];

   always #5 clk = ~clk;

   seq_detect_ctrl dut (
      .clk         (clk),
      .rst         (rst),
      .cfg_we      (cfg_we),
      .cfg_pattern (cfg_pattern),
      .cfg_len     (cfg_len),
      .cfg_overlap (cfg_overlap),
      .start       (start),
      .frame_len   (frame_len),
      .x           (x),
      .x_valid     (x_valid),
      .x_ready     (x_ready),
      .y           (y),
      .busy        (busy),
      .done        (done),
      .match_count (match_count),
      .state       (state)
   );

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic set_cfg(input logic [7:0] p, input logic [3:0] l, input bit o);
      cfg_we      = 1'b1;
      cfg_pattern = p;
      cfg_len     = l;
      cfg_overlap = o;
      m_pat = p;
      m_len = (l == 0) ? 1 : (l > 8) ? 8 : int'(l);
      m_ovl = o;
   endtask

   task automatic model_accept(input bit b, output bit m);
      q.push_back(b);
      since++;
      m = 1'b0;
      if (since >= m_len) begin
         m = 1'b1;
         for (int k = 0; k < m_len; k++)
            if (q[q.size()-1-k] != m_pat[k]) m = 1'b0;
      end
      if (m) begin
         m_cnt++;
         if (!m_ovl) since = 0;
      end
   endtask

   task automatic start_frame(input int n);
      start     = 1'b1;
      frame_len = n[7:0];
      tick();
      start  = 1'b0;
      cfg_we = 1'b0;
      m_cnt  = 0;
      since  = 0;
      q.delete();
      if (n != 0) begin
         check("run_state", state, 1);
         check("run_busy", busy, 1);
         check("run_ready", x_ready, 1);
         check("run_count0", match_count, 0);
         check("run_done0", done, 0);
      end else begin
         check("zlen_state", state, 2);
         check("zlen_done", done, 1);
         check("zlen_ready", x_ready, 0);
         check("zlen_busy", busy, 0);
         check("zlen_count", match_count, 0);
         tick();
         check("zlen_idle", state, 0);
         check("zlen_done_off", done, 0);
         check("zlen_ready_off", x_ready, 0);
      end
   endtask

   // vmode: 0 always valid, 1 every other cycle, 2 random; noise pokes start/cfg_we.
   task automatic feed(input int n, input int vmode, input bit noise);
      int acc = 0;
      int cyc = 0;
      bit finished = 1'b0;
      bit v, b, m;
      while (!finished && cyc < 4*n + 20) begin
         v = (vmode == 0) ? 1'b1 : (vmode == 1) ? (cyc % 2 == 0) : 1'($urandom_range(0, 1));
         if (v && stim.size() > 0) b = 1'(stim.pop_front());
         else b = 1'($urandom_range(0, 1));
         x_valid = v;
         x       = b;
         if (noise) begin
            cfg_we      = 1'($urandom_range(0, 1));
            start       = 1'($urandom_range(0, 1));
            cfg_pattern = 8'($urandom);
            cfg_len     = 4'($urandom);
            cfg_overlap = 1'($urandom_range(0, 1));
            frame_len   = 8'($urandom);
         end
         tick();
         cyc++;
         if (v) begin
            model_accept(b, m);
            acc++;
            check("y_accept", y, m);
            check("count", match_count, m_cnt);
            if (acc == n) begin
               check("done_pulse", done, 1);
               check("done_state", state, 2);
               check("done_busy", busy, 0);
               check("done_ready", x_ready, 0);
               finished = 1'b1;
            end else begin
               check("no_early_done", done, 0);
               check("still_run", state, 1);
            end
         end else begin
            check("y_idle_cycle", y, 0);
            check("count_hold", match_count, m_cnt);
         end
      end
      x_valid = 1'b0;
      cfg_we  = 1'b0;
      start   = 1'b0;
      check("frame_completed", finished, 1);
      x_valid = 1'b1;
      x       = 1'b1;
      tick();
      check("back_idle", state, 0);
      check("done_one_cycle", done, 0);
      check("y_after", y, 0);
      check("ready_after", x_ready, 0);
      check("count_after", match_count, m_cnt);
      tick();
      check("no_extra_bits", match_count, m_cnt);
      x_valid = 1'b0;
   endtask

   initial begin
      rst = 1'b0; cfg_we = 1'b0; cfg_pattern = '0; cfg_len = '0; cfg_overlap = 1'b0;
      start = 1'b0; frame_len = 8'd5; x = 1'b0; x_valid = 1'b1;
      m_pat = '0; m_len = 1; m_ovl = 1'b1; m_cnt = 0; since = 0;

      // Reset held with inputs toggling.
      for (int i = 0; i < 4; i++) begin
         x = ~x; start = ~start;
         tick();
         check("rst_state", state, 0);
         check("rst_y", y, 0);
         check("rst_busy", busy, 0);
         check("rst_done", done, 0);
         check("rst_ready", x_ready, 0);
         check("rst_count", match_count, 0);
      end
      start = 1'b0; x_valid = 1'b0;
      rst = 1'b1;
      tick();
      check("post_rst_idle", state, 0);

      // Pattern 1011, overlapping; config and start on the same edge.
      set_cfg(8'b1011, 4'd4, 1'b1);
      start_frame(7);
      stim = '{1, 0, 1, 1, 0, 1, 1};
      feed(7, 0, 1'b0);
      check("ovl_total", match_count, 2);

      // Same, non-overlapping.
      set_cfg(8'b1011, 4'd4, 1'b0);
      tick();
      cfg_we = 1'b0;
      start_frame(7);
      stim = '{1, 0, 1, 1, 0, 1, 1};
      feed(7, 0, 1'b0);
      check("novl_total", match_count, 1);

      // Overlapping with x_valid every other cycle.
      set_cfg(8'b1011, 4'd4, 1'b1);
      start_frame(7);
      stim = '{1, 0, 1, 1, 0, 1, 1};
      feed(7, 1, 1'b0);
      check("gap_total", match_count, 2);

      // Zero-length frame.
      start_frame(0);

      // Length 0 clamps to 1; config pokes during RUN must be ignored.
      set_cfg(8'h01, 4'd0, 1'b1);
      tick();
      cfg_we = 1'b0;
      start_frame(5);
      stim = '{1, 1, 1, 1, 1};
      feed(5, 2, 1'b1);
      check("len1_total", match_count, 5);

      // Over-long length clamps to 8.
      set_cfg(8'hA5, 4'd15, 1'b1);
      start_frame(12);
      stim = '{1, 0, 1, 0, 0, 1, 0, 1, 1, 0, 1, 0};
      feed(12, 0, 1'b0);
      check("len8_total", match_count, 1);

      // Reset mid-frame aborts without done and restores default config.
      set_cfg(8'h03, 4'd2, 1'b1);
      start_frame(10);
      x_valid = 1'b1; x = 1'b1;
      tick(); tick(); tick();
      #2 rst = 1'b0;
      #1;
      check("abort_state", state, 0);
      check("abort_busy", busy, 0);
      check("abort_done", done, 0);
      check("abort_ready", x_ready, 0);
      check("abort_count", match_count, 0);
      check("abort_y", y, 0);
      x_valid = 1'b0;
      tick();
      check("abort_no_done", done, 0);
      rst = 1'b1;
      m_pat = '0; m_len = 1; m_ovl = 1'b1;
      tick();
      start_frame(4);
      stim = '{0, 1, 0, 0};
      feed(4, 0, 1'b0);
      check("default_cfg_total", match_count, 3);

      // Randomized frames.
      for (int f = 0; f < 10; f++) begin
         set_cfg(8'($urandom), 4'($urandom_range(0, 15)), 1'($urandom_range(0, 1)));
         if (f % 2 == 0) begin
            tick();
            cfg_we = 1'b0;
         end
         start_frame($urandom_range(1, 40));
         feed(int'(frame_len), 2, 1'($urandom_range(0, 1)));
      end

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
